multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: run  in  1  when high, new fetches are permitted.
REQ-004 SHALL have ports:
- imem_req  out  1  fetch request.
- imem_addr  out  16  equals pc.
- imem_rdata  in  16  instruction word.
- imem_valid  in  1  imem_rdata valid this cycle.
REQ-005 SHALL have ports:
- dmem_req  out  1  data-memory request.
- dmem_we  out  1  1 = store.
- dmem_ready  in  1  access completes this cycle.
REQ-006 SHALL have ports:
- rf_ra  out  3  = ir[12:10].
- rf_rb  out  3  = ir[9:7].
- rf_rc  out  3  = ir[2:0].
- rf_we  out  1  register write strobe.
REQ-007 SHALL have ports:
- unit_sel  out  3  = ir[15:13].
- imm7  out  7  = ir[6:0], unsigned.
- imm10  out  10  = ir[9:0].
REQ-008 SHALL have ports:
- branch_pc  in  16  next PC from the BEQ unit.
- jalr_pc  in  16  next PC from the JALR unit (rb value).
REQ-009 SHALL have ports: pc  out  16  program counter; retire  out  1  one-cycle pulse per completed instruction.

Function
REQ-010 Opcode map, ir[15:13], SHALL be:
- 000 ADD
- 001 ADDI
- 010 SUBI
- 011 LUI
- 100 SW
- 101 LW
- 110 BEQ
- 111 JALR
REQ-011 State machine SHALL have states FETCH, DECODE, EXEC, MEM, WB; exactly one state is active per cycle.
REQ-012 FETCH, run=0: SHALL hold, with imem_req=0.
REQ-013 FETCH, run=1: SHALL drive imem_req=1 and imem_addr=pc.
REQ-014 FETCH, imem_valid=1 while imem_req=1: SHALL latch ir<=imem_rdata and go to DECODE; otherwise hold with imem_req high.
REQ-015 imem_valid while imem_req=0 SHALL be ignored.
REQ-016 DECODE SHALL last exactly one cycle, then go to EXEC; rf_ra/rf_rb/rf_rc/unit_sel/imm7/imm10 are driven combinationally from ir in every state.
REQ-017 EXEC SHALL last one cycle; next state is MEM for SW/LW, WB for every other opcode.
REQ-018 MEM SHALL drive dmem_req=1, with dmem_we=1 for SW and 0 for LW, until dmem_ready=1.
REQ-019 MEM with dmem_ready=1: SW SHALL update pc and go to FETCH; LW SHALL go to WB.
REQ-020 WB SHALL assert rf_we=1 for ADD, ADDI, SUBI, LUI, LW and JALR only when rf_ra!=0; rf_we SHALL be 0 in every other state/opcode.
REQ-021 PC update SHALL occur once per instruction, at the end of WB (or of MEM for SW):
- BEQ: pc<=branch_pc.
- JALR: pc<=jalr_pc.
- else: pc<=pc+1, modulo 2^16 (0xFFFF wraps to 0x0000).
REQ-022 retire SHALL pulse high in exactly the cycle the PC updates.
REQ-023 Latency SHALL be, with zero-wait memories:
- ALU/LUI/BEQ/JALR: 4 cycles FETCH-to-FETCH.
- SW: 4 cycles.
- LW: 5 cycles.
REQ-024 Deasserting run mid-instruction SHALL NOT abort it; the instruction completes and the FSM then idles in FETCH.
REQ-025 dmem_ready outside MEM SHALL be ignored.

Reset
REQ-026 rst_n low SHALL asynchronously force:
- state=FETCH.
- pc=0x0000.
- ir=0x0000.
- imem_req=0, dmem_req=0, dmem_we=0, rf_we=0, retire=0.
REQ-027 Reset asserted mid-instruction (any state, including MEM) SHALL discard the instruction with no rf_we and no pc update.
REQ-028 After rst_n rises, the first imem_req SHALL occur in the first cycle with run=1.

Verification
REQ-029 Reset, run=1, zero-wait imem, ADDI r1 (0x2405) at pc 0 -> imem_req in cycle 0, rf_we with rf_ra=1 in cycle 3, pc=0x0001 and retire pulse in cycle 3.
REQ-030 LW 0xA480 with dmem_ready delayed 3 cycles -> dmem_req/dmem_we=1/0 held 4 cycles, then WB rf_we=1, total 8 cycles, pc+1.
REQ-031 BEQ with branch_pc=0x0040 -> rf_we stays 0, pc=0x0040 after WB; JALR r2 with jalr_pc=0x1234 -> rf_we=1 with rf_ra=2, pc=0x1234.
REQ-032 pc=0xFFFF, ADD r0 -> rf_we stays 0 (ra=0), pc wraps to 0x0000, retire=1.
REQ-033 Drop run during EXEC of SW -> SW completes (dmem_we=1), pc+1, FSM idles in FETCH with imem_req=0.
REQ-034 Assert rst_n=0 in MEM of SW, with dmem_ready never high -> dmem_req drops immediately, pc=0, no retire pulse.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: five-state FETCH/DECODE/EXEC/MEM/WB sequencer for a 16-bit, 8-opcode core.
// Owns pc and ir; everything else the datapath needs is decoded straight from ir.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic [2:0]  rf_ra,
  output logic [2:0]  rf_rb,
  output logic [2:0]  rf_rc,
  output logic        rf_we,
  output logic [2:0]  unit_sel,
  output logic [6:0]  imm7,
  output logic [9:0]  imm10,
  input  logic [15:0] branch_pc,
  input  logic [15:0] jalr_pc,
  output logic [15:0] pc,
  output logic        retire
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  typedef enum logic [2:0] {OP_ADD, OP_ADDI, OP_SUBI, OP_LUI, OP_SW, OP_LW, OP_BEQ, OP_JALR} op_t;
  state_t      r_state, w_next;
  logic [15:0] r_ir, r_pc, w_pc_next;
  logic        w_upd, w_writes;
  op_t         w_op;
  assign w_op      = op_t'(r_ir[15:13]);
  assign unit_sel  = r_ir[15:13];
  assign rf_ra     = r_ir[12:10];
  assign rf_rb     = r_ir[9:7];
  assign rf_rc     = r_ir[2:0];
  assign imm7      = r_ir[6:0];
  assign imm10     = r_ir[9:0];
  assign pc        = r_pc;
  assign imem_addr = r_pc;
  assign retire    = w_upd;
  assign w_writes  = !(w_op == OP_SW || w_op == OP_BEQ);
  assign w_pc_next = w_op == OP_BEQ ? branch_pc : w_op == OP_JALR ? jalr_pc : r_pc + 16'd1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= FETCH;
      r_pc    <= 16'h0000;
      r_ir    <= 16'h0000;
    end else begin
      r_state <= w_next;
      if (imem_req && imem_valid) r_ir <= imem_rdata;
      if (w_upd) r_pc <= w_pc_next;
    end
  // imem_req is gated by rst_n so a high run cannot leak a request out during reset
  always_comb begin
    w_next   = r_state;
    imem_req = 1'b0;
    dmem_req = 1'b0;
    dmem_we  = 1'b0;
    rf_we    = 1'b0;
    w_upd    = 1'b0;
    case (r_state)
      FETCH: begin
        imem_req = run & rst_n;
        w_next   = (imem_req && imem_valid) ? DECODE : FETCH;
      end
      DECODE: w_next = EXEC;
      EXEC:   w_next = (w_op == OP_SW || w_op == OP_LW) ? MEM : WB;
      MEM: begin
        dmem_req = 1'b1;
        dmem_we  = w_op == OP_SW;
        w_upd    = dmem_ready && w_op == OP_SW;
        w_next   = !dmem_ready ? MEM : w_op == OP_SW ? FETCH : WB;
      end
      WB: begin
        rf_we  = w_writes && rf_ra != 3'd0;
        w_upd  = 1'b1;
        w_next = FETCH;
      end
      default: w_next = FETCH;
    endcase
  end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: directed scenario tasks with hand-computed expectations for multicycle_ctrl.
module tb_multicycle_ctrl;
  logic        clk = 1'b0;
  logic        rst_n, run, imem_req, imem_valid, dmem_req, dmem_we, dmem_ready, rf_we, retire;
  logic [15:0] imem_addr, imem_rdata, branch_pc, jalr_pc, pc;
  logic [2:0]  rf_ra, rf_rb, rf_rc, unit_sel;
  logic [6:0]  imm7;
  logic [9:0]  imm10;
  int pass = 0, total = 0;
  always #5 clk = ~clk;
  multicycle_ctrl dut (
    .clk(clk), .rst_n(rst_n), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_rc(rf_rc), .rf_we(rf_we),
    .unit_sel(unit_sel), .imm7(imm7), .imm10(imm10),
    .branch_pc(branch_pc), .jalr_pc(jalr_pc), .pc(pc), .retire(retire)
  );
  task automatic test_reset;
    @(negedge clk); @(negedge clk);
    total++; if (imem_req !== 1'b0) $display("FAIL rst_imem_req: got %h exp 0", imem_req); else pass++;
    total++; if (pc !== 16'h0000) $display("FAIL rst_pc: got %h exp 0000", pc); else pass++;
    total++; if ({dmem_req, dmem_we, rf_we, retire} !== 4'b0) $display("FAIL rst_strobes: got %b exp 0000", {dmem_req, dmem_we, rf_we, retire}); else pass++;
    total++; if (unit_sel !== 3'd0 || rf_ra !== 3'd0) $display("FAIL rst_ir: got %h/%h exp 0/0", unit_sel, rf_ra); else pass++;
    run = 1'b1; #1;
    total++; if (imem_req !== 1'b0) $display("FAIL rst_run_gated: got %h exp 0", imem_req); else pass++;
    run = 1'b0;
    @(negedge clk);
    rst_n = 1'b1; imem_valid = 1'b1; imem_rdata = 16'h2405;
    @(negedge clk); @(negedge clk);
    total++; if (imem_req !== 1'b0) $display("FAIL idle_no_req: got %h exp 0", imem_req); else pass++;
    total++; if (unit_sel !== 3'd0 || rf_ra !== 3'd0) $display("FAIL idle_valid_ignored: got %h/%h exp 0/0", unit_sel, rf_ra); else pass++;
  endtask
  task automatic test_addi;
    run = 1'b1; #1;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) $display("FAIL addi_fetch: got %h/%h exp 1/0000", imem_req, imem_addr); else pass++;
    @(negedge clk); run = 1'b0;
    total++; if (imem_req !== 1'b0) $display("FAIL addi_dec_req: got %h exp 0", imem_req); else pass++;
    total++; if ({unit_sel, rf_ra, rf_rb, rf_rc} !== {3'd1, 3'd1, 3'd0, 3'd5}) $display("FAIL addi_fields: got %h exp %h", {unit_sel, rf_ra, rf_rb, rf_rc}, {3'd1, 3'd1, 3'd0, 3'd5}); else pass++;
    total++; if (imm7 !== 7'h05 || imm10 !== 10'h005) $display("FAIL addi_imm: got %h/%h exp 05/005", imm7, imm10); else pass++;
    @(negedge clk);
    total++; if (rf_we !== 1'b0 || retire !== 1'b0) $display("FAIL addi_exec: got %b%b exp 00", rf_we, retire); else pass++;
    @(negedge clk);
    total++; if (rf_we !== 1'b1 || rf_ra !== 3'd1 || retire !== 1'b1) $display("FAIL addi_wb: got %b/%h/%b exp 1/1/1", rf_we, rf_ra, retire); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'h0001 || retire !== 1'b0 || imem_req !== 1'b0) $display("FAIL addi_done: got %h/%b/%b exp 0001/0/0", pc, retire, imem_req); else pass++;
  endtask
  task automatic test_lw_wait;
    int mem_cycles = 0;
    imem_rdata = 16'hA480; run = 1'b1;
    @(negedge clk); run = 1'b0; dmem_ready = 1'b1;
    @(negedge clk); dmem_ready = 1'b0;
    total++; if (dmem_req !== 1'b0) $display("FAIL lw_exec_dreq: got %h exp 0", dmem_req); else pass++;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (dmem_req === 1'b1 && dmem_we === 1'b0) mem_cycles++;
      if (k == 3) dmem_ready = 1'b1;
    end
    total++; if (mem_cycles !== 4) $display("FAIL lw_mem_cycles: got %0d exp 4", mem_cycles); else pass++;
    @(negedge clk); dmem_ready = 1'b0;
    total++; if ({dmem_req, rf_we, rf_ra, retire} !== {1'b0, 1'b1, 3'd1, 1'b1}) $display("FAIL lw_wb: got %b exp %b", {dmem_req, rf_we, rf_ra, retire}, {1'b0, 1'b1, 3'd1, 1'b1}); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'h0002) $display("FAIL lw_pc: got %h exp 0002", pc); else pass++;
  endtask
  task automatic test_beq_jalr;
    imem_rdata = 16'hC400; branch_pc = 16'h0040; imem_valid = 1'b0; run = 1'b1;
    @(negedge clk);
    total++; if (imem_req !== 1'b1) $display("FAIL beq_imem_wait: got %h exp 1", imem_req); else pass++;
    imem_valid = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rf_we !== 1'b0 || retire !== 1'b1) $display("FAIL beq_wb: got %b%b exp 01", rf_we, retire); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'h0040) $display("FAIL beq_pc: got %h exp 0040", pc); else pass++;
    imem_rdata = 16'hE800; jalr_pc = 16'h1234; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rf_we !== 1'b1 || rf_ra !== 3'd2 || retire !== 1'b1) $display("FAIL jalr_wb: got %b/%h/%b exp 1/2/1", rf_we, rf_ra, retire); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'h1234) $display("FAIL jalr_pc: got %h exp 1234", pc); else pass++;
  endtask
  task automatic test_wrap;
    imem_rdata = 16'hE000; jalr_pc = 16'hFFFF; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rf_we !== 1'b0) $display("FAIL jalr_r0_we: got %h exp 0", rf_we); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'hFFFF) $display("FAIL wrap_setup_pc: got %h exp ffff", pc); else pass++;
    imem_rdata = 16'h0000; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (rf_we !== 1'b0 || retire !== 1'b1) $display("FAIL add_r0_wb: got %b%b exp 01", rf_we, retire); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'h0000 || retire !== 1'b0) $display("FAIL wrap_pc: got %h/%b exp 0000/0", pc, retire); else pass++;
  endtask
  task automatic test_run_drop;
    imem_rdata = 16'h8485; dmem_ready = 1'b1; run = 1'b1;
    @(negedge clk);
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    total++; if ({dmem_req, dmem_we, retire, rf_we} !== 4'b1110) $display("FAIL sw_mem: got %b exp 1110", {dmem_req, dmem_we, retire, rf_we}); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'h0001 || imem_req !== 1'b0 || dmem_req !== 1'b0) $display("FAIL sw_done: got %h/%b/%b exp 0001/0/0", pc, imem_req, dmem_req); else pass++;
    @(negedge clk);
    total++; if (pc !== 16'h0001 || imem_req !== 1'b0) $display("FAIL sw_idle: got %h/%b exp 0001/0", pc, imem_req); else pass++;
  endtask
  task automatic test_reset_mid;
    int strobes = 0;
    dmem_ready = 1'b0; run = 1'b1;
    @(negedge clk); run = 1'b0;
    @(negedge clk);
    @(negedge clk);
    total++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) $display("FAIL rmid_in_mem: got %b%b exp 11", dmem_req, dmem_we); else pass++;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({dmem_req, dmem_we, retire} !== 3'b000 || pc !== 16'h0000) $display("FAIL rmid_async: got %b/%h exp 000/0000", {dmem_req, dmem_we, retire}, pc); else pass++;
    dmem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (retire === 1'b1 || rf_we === 1'b1 || dmem_req === 1'b1) strobes++;
    end
    total++; if (strobes !== 0 || pc !== 16'h0000) $display("FAIL rmid_quiet: got %0d/%h exp 0/0000", strobes, pc); else pass++;
    rst_n = 1'b1; dmem_ready = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL timeout: got no finish exp finish");
    $fatal(1, "timeout");
  end
  initial begin
    rst_n = 1'b0; run = 1'b0; imem_valid = 1'b0; imem_rdata = 16'h0000;
    dmem_ready = 1'b0; branch_pc = 16'h0000; jalr_pc = 16'h0000;
    test_reset;
    test_addi;
    test_lw_wait;
    test_beq_jalr;
    test_wrap;
    test_run_drop;
    test_reset_mid;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
